dsp_mac_pipe: RTL and testbench
===============================

Name: dsp_mac_pipe

Overview:
- Parametrised successor to the fixed 18x18/48-bit pre-add/multiply/post-add DSP pipeline.
- Adds run-time opmode per sample, valid tagging, clock enable, an accumulate path (P feedback), full-precision pre-adder, signed/unsigned arithmetic and optional saturation with an overflow flag.
- Used as the MAC engine behind filter and correlator datapaths.

Parameters:
- A_W, 18, width of multiplier operand a.
- B_W, 18, width of pre-adder operand b.
- D_W, 18, width of pre-adder operand d.
- C_W, 48, width of post-adder operand c (C_W <= P_W).
- P_W, 48, width of result p (P_W >= PRE_W + A_W).
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- SATURATE, 0, 1 = clamp the post-adder result on overflow, 0 = wrap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; all pipeline stages advance only when ce=1.
- in_valid  in  1  qualifies a, b, d, c and opmode.
- a  in  A_W  multiplier operand.
- b  in  B_W  pre-adder operand.
- d  in  D_W  pre-adder operand.
- c  in  C_W  post-adder operand.
- opmode  in  5  per-sample mode word:
  - [0] pre_sub: 0 gives d+b, 1 gives d-b.
  - [1] pre_bypass: 1 gives b only.
  - [2] post_sub: 0 gives Z+M, 1 gives M-Z.
  - [4:3] z_sel: 00 zero, 01 c, 10 p feedback, 11 reserved (treated as zero).
- out_valid  out  1  one-cycle pulse per completed result.
- p  out  P_W  result; holds between results.
- overflow  out  1  the post-adder result for the current p overflowed P_W; updated together with p.

Behaviour:
- Reset: every pipeline register, including p, overflow and out_valid, clears to 0. rst overrides ce. A reset mid-flight discards all in-flight samples: no out_valid follows for them.
- Latency: exactly 4 ce-qualified cycles from sampling in_valid=1 to out_valid=1. There is one sample per ce cycle, so throughput is 1/cycle.
- Stage 1 registers a, b, d, c, opmode and in_valid, and takes in_valid into the valid shift chain v1..v4.
- Stage 2, pre-adder:
  - PRE_W = max(B_W, D_W) + 1.
  - Operands are sign- or zero-extended per SIGNED; there is no truncation.
  - pre_bypass takes priority over pre_sub.
  - a and c are delayed in step with the pre-adder.
- Stage 3, multiplier:
  - M = pre x a, full product of width PRE_W + A_W.
  - M is extended to P_W per SIGNED.
- Stage 4, post-adder and P register:
  - Z is selected by z_sel; c is extended to P_W per SIGNED.
  - The sum is computed at P_W+1 bits.
  - overflow is set when:
    - SIGNED=1: the result falls outside the signed P_W range;
    - SIGNED=0: a carry out occurs (Z+M) or a borrow occurs (M-Z).
  - SATURATE=1: on overflow, p is clamped to the bound of the range that was exceeded (signed max/min, or unsigned all-ones/0).
  - SATURATE=0: p takes the low P_W bits.
- P register and overflow load only when ce=1 and v3=1; otherwise they hold. Bubbles (in_valid=0) never change p or the accumulation.
- Accumulate (z_sel=10) uses the current P register.
  - Back-to-back valid samples accumulate correctly through the single-cycle feedback loop, with no hazard.
  - The first sample of a new sum uses z_sel=00 or 01.
- out_valid register loads (ce & v3) every cycle. It is therefore low during stalls and never repeats a result.
- ce=0: all data and valid registers hold, except out_valid, which clears.
- Simultaneous rst and ce: reset wins.
- Reserved z_sel=11 behaves as zero; it is not flagged.

Decomposition:
- Shared package dsp_pkg holds:
  - opmode bit positions and the width constant OPMODE_W=5;
  - the z_sel encodings Z_ZERO, Z_C, Z_P, Z_RSVD;
  - a max() width function for PRE_W.
- One natural sub-module: dsp_pipe_reg, a parametrised-width register with synchronous active-high reset and enable. It is instantiated for every stage and for the valid chain.

Test Plan:
- Defaults, with opmode=z_sel C, add, d=10, b=3, a=4, c=100, in_valid=1 for one cycle -> out_valid pulses 4 cycles later; p=152, overflow=0.
- pre_sub=1 with d=5, b=8, a=-3, z_sel zero -> p=9. Repeat with SIGNED=0 and d=8, b=5, a=3 -> p=9.
- Accumulate: pre_bypass=1 with b=1, a=2 on 4 consecutive valid cycles. The first has z_sel zero, the rest z_sel P -> p=2, 4, 6, 8 on 4 consecutive out_valid cycles. Insert bubbles between samples -> same final p=8, with no extra out_valid.
- Stall: deassert ce for 3 cycles while 2 samples are in flight -> out_valid stays low during the stall; results appear in order after ce returns; total latency is 4 ce cycles each.
- Saturation (P_W=20, C_W=20, SATURATE=1):
  - c=524287, M=1, add -> p=524287, overflow=1.
  - With SATURATE=0 -> p=-524288, overflow=1.
- Reset mid-flight: assert rst for 1 cycle with 3 samples in flight -> p=0, out_valid=0, and no out_valid for those samples; the next new sample completes normally 4 cycles later.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP MAC pipeline: opmode layout, z_sel encodings
// and a width helper.
package dsp_pkg;

  localparam int OPMODE_W      = 5;
  localparam int OP_PRE_SUB    = 0;
  localparam int OP_PRE_BYPASS = 1;
  localparam int OP_POST_SUB   = 2;
  localparam int OP_ZSEL_LO    = 3;
  localparam int OP_ZSEL_HI    = 4;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_C    = 2'b01,
    Z_P    = 2'b10,
    Z_RSVD = 2'b11
  } zsel_e;

  function automatic int max_w(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Generic pipeline register with synchronous active-high reset and load enable.
module dsp_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Four-stage pre-add / multiply / post-add MAC with per-sample opmode,
// P feedback accumulation and optional saturation.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int D_W      = 18,
  parameter int C_W      = 48,
  parameter int P_W      = 48,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                in_valid,
  input  logic [A_W-1:0]      a,
  input  logic [B_W-1:0]      b,
  input  logic [D_W-1:0]      d,
  input  logic [C_W-1:0]      c,
  input  logic [OPMODE_W-1:0] opmode,
  output logic                out_valid,
  output logic [P_W-1:0]      p,
  output logic                overflow
);

  localparam int PRE_W = max_w(B_W, D_W) + 1;
  localparam int M_W   = PRE_W + A_W;

  logic [A_W-1:0]      a1, a2;
  logic [B_W-1:0]      b1;
  logic [D_W-1:0]      d1;
  logic [C_W-1:0]      c1, c2, c3;
  logic [OPMODE_W-1:0] op1;
  // op2/op3 carry only {z_sel, post_sub}: bit 0 = post_sub, bits 2:1 = z_sel
  logic [2:0]          op2, op3;
  logic [3:0]          v;
  logic [PRE_W-1:0]    b_ext, d_ext, pre_next, pre2;
  logic [M_W-1:0]      pre_m, a_m, m_next, m3;
  logic [P_W-1:0]      c_p, m_p, z_p, p_next, clamp;
  logic [P_W:0]        z_x, m_x, sum;
  logic                ovf_next;
  zsel_e               z_sel;

  dsp_pipe_reg #(.W(A_W + B_W + D_W + C_W + OPMODE_W)) u_s1 (
    .clk(clk), .rst(rst), .en(ce),
    .d({a, b, d, c, opmode}),
    .q({a1, b1, d1, c1, op1})
  );

  assign v[0] = in_valid;
  for (genvar gi = 0; gi < 3; gi++) begin : g_valid
    dsp_pipe_reg #(.W(1)) u_v (
      .clk(clk), .rst(rst), .en(ce), .d(v[gi]), .q(v[gi+1])
    );
  end

  if (SIGNED != 0) begin : g_signed
    assign b_ext = PRE_W'($signed(b1));
    assign d_ext = PRE_W'($signed(d1));
    assign pre_m = M_W'($signed(pre2));
    assign a_m   = M_W'($signed(a2));
    assign m_p   = P_W'($signed(m3));
    assign c_p   = P_W'($signed(c3));
    assign m_x   = (P_W+1)'($signed(m_p));
    assign z_x   = (P_W+1)'($signed(z_p));
  end else begin : g_unsigned
    assign b_ext = PRE_W'(b1);
    assign d_ext = PRE_W'(d1);
    assign pre_m = M_W'(pre2);
    assign a_m   = M_W'(a2);
    assign m_p   = P_W'(m3);
    assign c_p   = P_W'(c3);
    assign m_x   = (P_W+1)'(m_p);
    assign z_x   = (P_W+1)'(z_p);
  end

  always_comb begin
    pre_next = d_ext + b_ext;
    if (op1[OP_PRE_BYPASS]) begin
      pre_next = b_ext;
    end else if (op1[OP_PRE_SUB]) begin
      pre_next = d_ext - b_ext;
    end
  end

  dsp_pipe_reg #(.W(PRE_W + A_W + C_W + 3)) u_s2 (
    .clk(clk), .rst(rst), .en(ce),
    .d({pre_next, a1, c1, op1[OP_ZSEL_HI:OP_POST_SUB]}),
    .q({pre2, a2, c2, op2})
  );

  // Operands are pre-extended to the full product width, so the low M_W
  // bits of an unsigned multiply are exact for both signednesses.
  assign m_next = pre_m * a_m;

  dsp_pipe_reg #(.W(M_W + C_W + 3)) u_s3 (
    .clk(clk), .rst(rst), .en(ce),
    .d({m_next, c2, op2}),
    .q({m3, c3, op3})
  );

  always_comb begin
    z_sel = zsel_e'(op3[2:1]);
    case (z_sel)
      Z_C:     z_p = c_p;
      Z_P:     z_p = p;
      default: z_p = '0;
    endcase
  end

  always_comb begin
    sum = op3[0] ? (m_x - z_x) : (z_x + m_x);
    if (SIGNED != 0) begin
      ovf_next = sum[P_W] ^ sum[P_W-1];
      clamp    = sum[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
    end else begin
      // extra bit is carry for Z+M and borrow for M-Z
      ovf_next = sum[P_W];
      clamp    = op3[0] ? '0 : '1;
    end
    p_next = ((SATURATE != 0) && ovf_next) ? clamp : sum[P_W-1:0];
  end

  dsp_pipe_reg #(.W(P_W + 1)) u_p (
    .clk(clk), .rst(rst), .en(ce & v[3]),
    .d({ovf_next, p_next}),
    .q({overflow, p})
  );

  dsp_pipe_reg #(.W(1)) u_ov (
    .clk(clk), .rst(rst), .en(1'b1), .d(ce & v[3]), .q(out_valid)
  );

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench: four configurations of dsp_mac_pipe against an
// integer reference model, plus directed vectors and corner sequences.
module tb_dsp_mac_pipe;
  import dsp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, in_valid;
  logic [4:0]  opmode;
  logic [17:0] a_w, b_w, d_w;
  logic [47:0] c_w;
  logic [1:0]  a_n;
  logic [7:0]  b_n, d_n;
  logic [19:0] c_n;
  logic [3:0]  ov, ovf;
  logic [47:0] p0, p1;
  logic [19:0] p2, p3;

  int checks = 0;
  int errors = 0;
  int ce_edges = 0;
  int pulses0 = 0;

  dsp_mac_pipe u_dut0 (.clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a_w), .b(b_w), .d(d_w),
    .c(c_w), .opmode(opmode), .out_valid(ov[0]), .p(p0), .overflow(ovf[0]));
  dsp_mac_pipe #(.SIGNED(0)) u_dut1 (.clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a_w),
    .b(b_w), .d(d_w), .c(c_w), .opmode(opmode), .out_valid(ov[1]), .p(p1), .overflow(ovf[1]));
  dsp_mac_pipe #(.A_W(2), .B_W(8), .D_W(8), .C_W(20), .P_W(20), .SIGNED(1), .SATURATE(1)) u_dut2 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a_n), .b(b_n), .d(d_n), .c(c_n),
    .opmode(opmode), .out_valid(ov[2]), .p(p2), .overflow(ovf[2]));
  dsp_mac_pipe #(.A_W(2), .B_W(8), .D_W(8), .C_W(20), .P_W(20), .SIGNED(1), .SATURATE(0)) u_dut3 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a_n), .b(b_n), .d(d_n), .c(c_n),
    .opmode(opmode), .out_valid(ov[3]), .p(p3), .overflow(ovf[3]));

  function automatic longint get_p(input int i);
    case (i)
      0:       return longint'($signed(p0));
      1:       return longint'(p1);
      2:       return longint'($signed(p2));
      default: return longint'($signed(p3));
    endcase
  endfunction

  function automatic logic [4:0] mk_op(input logic [1:0] z, input bit post_sub, input bit bypass, input bit pre_sub);
    return {z, post_sub, bypass, pre_sub};
  endfunction

  // Arithmetic meaning of one sample, with plain integers and range checks.
  function automatic void model(input bit sg, input int pw, input int prew, input bit sat,
                                input longint av, input longint bv, input longint dv, input longint cv,
                                input logic [4:0] op, input longint pprev,
                                output longint pn, output bit o);
    longint pre, m, z, s, lo, hi, span;
    span = longint'(1) <<< pw;
    if (op[1]) pre = bv;
    else if (op[0]) pre = dv - bv;
    else pre = dv + bv;
    if (!sg) pre = pre & ((longint'(1) <<< prew) - 1);
    m = pre * av;
    case (op[4:3])
      2'b01:   z = cv;
      2'b10:   z = pprev;
      default: z = 0;
    endcase
    s  = op[2] ? m - z : z + m;
    lo = sg ? -(span / 2) : 0;
    hi = sg ? span / 2 - 1 : span - 1;
    o  = (s > hi) || (s < lo);
    if (o && sat) begin
      pn = (s > hi) ? hi : lo;
    end else begin
      pn = s & (span - 1);
      if (sg && pn > hi) pn = pn - span;
    end
  endfunction

  typedef struct {
    longint p;
    bit     o;
    int     cnt;
  } exp_t;

  exp_t   sbq[4][$];
  longint mp[4];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sbq[i].delete();
        mp[i] = 0;
      end
    end else if (ce) begin
      if (in_valid) begin
        for (int i = 0; i < 4; i++) begin
          longint av, bv, dv, cv, pn;
          bit o;
          exp_t e;
          case (i)
            0: begin
              av = longint'($signed(a_w)); bv = longint'($signed(b_w));
              dv = longint'($signed(d_w)); cv = longint'($signed(c_w));
              model(1'b1, 48, 19, 1'b0, av, bv, dv, cv, opmode, mp[i], pn, o);
            end
            1: begin
              av = longint'(a_w); bv = longint'(b_w); dv = longint'(d_w); cv = longint'(c_w);
              model(1'b0, 48, 19, 1'b0, av, bv, dv, cv, opmode, mp[i], pn, o);
            end
            default: begin
              av = longint'($signed(a_n)); bv = longint'($signed(b_n));
              dv = longint'($signed(d_n)); cv = longint'($signed(c_n));
              model(1'b1, 20, 9, (i == 2), av, bv, dv, cv, opmode, mp[i], pn, o);
            end
          endcase
          e.p = pn;
          e.o = o;
          e.cnt = ce_edges;
          sbq[i].push_back(e);
          mp[i] = pn;
        end
      end
      ce_edges++;
    end
  end

  always @(negedge clk) begin
    if (ov[0]) pulses0++;
    for (int i = 0; i < 4; i++) begin
      if (ov[i]) begin
        exp_t e;
        checks++;
        if (sbq[i].size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected dut%0d: out_valid=1 with no result pending, p=%0d", i, get_p(i));
        end else begin
          e = sbq[i].pop_front();
          if (get_p(i) != e.p || ovf[i] != e.o || ce_edges - e.cnt != 4) begin
            errors++;
            $display("FAIL sb_result dut%0d: got p=%0d ovf=%0b lat=%0d, expected p=%0d ovf=%0b lat=4",
                     i, get_p(i), ovf[i], ce_edges - e.cnt, e.p, e.o);
          end else begin
            $display("sb dut%0d p=%0d ovf=%0b", i, e.p, e.o);
          end
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input longint a, input longint b, input longint d, input longint c,
                       input logic [4:0] op, input bit vld);
    a_w = a[17:0]; b_w = b[17:0]; d_w = d[17:0]; c_w = c[47:0];
    a_n = a[1:0];  b_n = b[7:0];  d_n = d[7:0];  c_n = c[19:0];
    opmode = op;
    in_valid = vld;
  endtask

  typedef struct {
    int         dut;
    longint     a, b, d, c;
    logic [4:0] op;
    longint     p;
    bit         o;
  } vec_t;

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    drive(v.a, v.b, v.d, v.c, v.op, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    check($sformatf("vec_valid dut%0d", v.dut), longint'(ov[v.dut]), 1);
    check($sformatf("vec_p dut%0d", v.dut), get_p(v.dut), v.p);
    check($sformatf("vec_ovf dut%0d", v.dut), longint'(ovf[v.dut]), longint'(v.o));
    $display("vec dut%0d p=%0d ovf=%0b", v.dut, get_p(v.dut), ovf[v.dut]);
  endtask

  vec_t tbl[14];
  int   snap;

  initial begin
    tbl[0]  = '{0, 4, 3, 10, 100, mk_op(Z_C, 0, 0, 0), 152, 1'b0};
    tbl[1]  = '{0, -3, 8, 5, 0, mk_op(Z_ZERO, 0, 0, 1), 9, 1'b0};
    tbl[2]  = '{1, 3, 5, 8, 0, mk_op(Z_ZERO, 0, 0, 1), 9, 1'b0};
    tbl[3]  = '{2, 1, 1, 0, 524287, mk_op(Z_C, 0, 1, 0), 524287, 1'b1};
    tbl[4]  = '{3, 1, 1, 0, 524287, mk_op(Z_C, 0, 1, 0), -524288, 1'b1};
    tbl[5]  = '{2, 1, 1, 0, -524288, mk_op(Z_C, 1, 1, 0), 524287, 1'b1};
    tbl[6]  = '{3, 1, 1, 0, -524288, mk_op(Z_C, 1, 1, 0), -524287, 1'b1};
    tbl[7]  = '{2, 1, -1, 0, -524288, mk_op(Z_C, 0, 1, 0), -524288, 1'b1};
    tbl[8]  = '{3, 1, -1, 0, -524288, mk_op(Z_C, 0, 1, 0), 524287, 1'b1};
    tbl[9]  = '{1, 1, 1, 0, 5, mk_op(Z_C, 1, 1, 0), 64'h0000_FFFF_FFFF_FFFC, 1'b1};
    tbl[10] = '{0, 4, 3, 10, 100, mk_op(Z_RSVD, 0, 0, 0), 52, 1'b0};
    tbl[11] = '{0, 4, 3, 10, 0, mk_op(Z_ZERO, 0, 1, 1), 12, 1'b0};
    tbl[12] = '{1, 1, 1, 0, 64'h0000_FFFF_FFFF_FFFF, mk_op(Z_C, 0, 1, 0), 0, 1'b1};
    tbl[13] = '{0, 1, 1, 0, 64'h0000_7FFF_FFFF_FFFF, mk_op(Z_C, 0, 1, 0), -64'sh0000_8000_0000_0000, 1'b1};

    rst = 1'b1;
    ce = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_out_valid", longint'(ov), 0);
    check("rst_p0", get_p(0), 0);
    check("rst_p2", get_p(2), 0);
    check("rst_overflow", longint'(ovf), 0);
    rst = 1'b0;
    ce = 1'b1;

    for (int i = 0; i < 14; i++) apply_vec(tbl[i]);

    // back-to-back accumulation through the P feedback
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(2, 1, 0, 0, mk_op((k == 0) ? Z_ZERO : Z_P, 0, 1, 0), 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(0, 0, 0, 0, 5'd0, 1'b0);
      check($sformatf("acc_valid%0d", k), longint'(ov[0]), 1);
      check($sformatf("acc_p%0d", k), get_p(0), 2 * (k + 1));
    end

    // same accumulation with bubbles between samples
    @(negedge clk);
    snap = pulses0;
    for (int k = 0; k < 4; k++) begin
      drive(2, 1, 0, 0, mk_op((k == 0) ? Z_ZERO : Z_P, 0, 1, 0), 1'b1);
      @(negedge clk);
      drive(0, 0, 0, 0, 5'd0, 1'b0);
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("bubble_pulses", longint'(pulses0 - snap), 4);
    check("bubble_p", get_p(0), 8);

    // clock-enable stall with two samples in flight
    snap = pulses0;
    drive(5, 1, 0, 0, mk_op(Z_ZERO, 0, 1, 0), 1'b1);
    @(negedge clk);
    drive(7, 1, 0, 0, mk_op(Z_ZERO, 0, 1, 0), 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 5'd0, 1'b0);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_valid%0d", k), longint'(ov[0]), 0);
    end
    ce = 1'b1;
    repeat (6) @(negedge clk);
    check("stall_pulses", longint'(pulses0 - snap), 2);
    check("stall_p", get_p(0), 7);

    // reset with three samples in flight
    snap = pulses0;
    for (int k = 0; k < 3; k++) begin
      drive(3, 1, 0, 0, mk_op(Z_ZERO, 0, 1, 0), 1'b1);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 5'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_p", get_p(0), 0);
    check("midrst_valid", longint'(ov), 0);
    check("midrst_ovf", longint'(ovf), 0);
    repeat (8) @(negedge clk);
    check("midrst_pulses", longint'(pulses0 - snap), 0);
    apply_vec(tbl[0]);

    // randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      ce = ($urandom_range(0, 9) != 0);
      drive(longint'($urandom), longint'($urandom), longint'($urandom),
            longint'({$urandom, $urandom}), 5'($urandom), ($urandom_range(0, 3) != 0));
    end
    @(negedge clk);
    ce = 1'b1;
    drive(0, 0, 0, 0, 5'd0, 1'b0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("drain_empty dut%0d", i), longint'(sbq[i].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
